// File: rtl/can_crc_check_if.sv
// Bus between the destuff/bit-timing front end (master) and the CRC-15
// checker (slave): received bit stream in, CRC values and verdict out.
interface can_crc_check_if;
   logic        rx_bit;
   logic        rx_valid;
   logic        sof;
   logic        last_data;
   logic        abort;
   logic        busy;
   logic [14:0] crc_calc;
   logic [14:0] crc_rx;
   logic        crc_done;
   logic        crc_ok;
   logic        crc_err;
   logic        delim_err;

   modport master (
      output rx_bit, rx_valid, sof, last_data, abort,
      input  busy, crc_calc, crc_rx, crc_done, crc_ok, crc_err, delim_err
   );

   modport slave (
      input  rx_bit, rx_valid, sof, last_data, abort,
      output busy, crc_calc, crc_rx, crc_done, crc_ok, crc_err, delim_err
   );
endinterface

// File: rtl/can_crc_check.sv
// Receive-side CAN CRC-15 checker. Runs the CRC over SOF..last data bit,
// captures the 15 transmitted CRC bits plus delimiter, and reports
// match / CRC error / delimiter form error. All outputs are registered.
module can_crc_check #(
   parameter logic [14:0] POLY = 15'h4599
) (
   input  logic           clk,
   input  logic           n_rst,
   can_crc_check_if.slave bus
);

   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, CRC_RX = 2'd2, DELIM = 2'd3} state_t;

   state_t      r_state, w_state_nxt;
   logic [14:0] r_crc_calc, r_crc_rx;
   logic [3:0]  r_cnt;
   logic        r_busy, r_done, r_ok, r_err, r_derr;

   logic [14:0] w_crc_calc_nxt, w_crc_rx_nxt;
   logic [3:0]  w_cnt_nxt;
   logic        w_done_nxt, w_ok_nxt, w_err_nxt, w_derr_nxt;
   logic        w_start;

   // One serial CRC step; the x^15 term falls off the top.
   function automatic logic [14:0] crc_step(input logic [14:0] crc, input logic b);
      logic fb;
      fb = b ^ crc[14];
      return {crc[13:0], 1'b0} ^ (fb ? POLY : 15'h0);
   endfunction

   // A qualified SOF restarts the frame from any state unless aborted.
   assign w_start = bus.rx_valid & bus.sof & ~bus.abort;

   // State register
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state logic: abort > sof restart > normal bit progression
   always_comb begin
      w_state_nxt = r_state;
      if (bus.abort) begin
         w_state_nxt = IDLE;
      end else if (w_start) begin
         w_state_nxt = bus.last_data ? CRC_RX : CALC;
      end else if (bus.rx_valid) begin
         case (r_state)
            CALC:    if (bus.last_data) w_state_nxt = CRC_RX;
            CRC_RX:  if (r_cnt == 4'd14) w_state_nxt = DELIM;
            DELIM:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   // Output/datapath next values; crc_calc and crc_rx hold on abort
   always_comb begin
      w_crc_calc_nxt = r_crc_calc;
      w_crc_rx_nxt   = r_crc_rx;
      w_cnt_nxt      = r_cnt;
      w_done_nxt     = 1'b0;
      w_ok_nxt       = r_ok;
      w_err_nxt      = r_err;
      w_derr_nxt     = r_derr;
      if (bus.abort) begin
         w_ok_nxt   = 1'b0;
         w_err_nxt  = 1'b0;
         w_derr_nxt = 1'b0;
      end else if (w_start) begin
         w_crc_calc_nxt = crc_step(15'h0, bus.rx_bit);
         w_crc_rx_nxt   = 15'h0;
         w_cnt_nxt      = 4'd0;
         w_ok_nxt       = 1'b0;
         w_err_nxt      = 1'b0;
         w_derr_nxt     = 1'b0;
      end else if (bus.rx_valid) begin
         case (r_state)
            CALC: begin
               w_crc_calc_nxt = crc_step(r_crc_calc, bus.rx_bit);
               if (bus.last_data) w_cnt_nxt = 4'd0;
            end
            CRC_RX: begin
               w_crc_rx_nxt = {r_crc_rx[13:0], bus.rx_bit};
               w_cnt_nxt    = r_cnt + 4'd1;
            end
            DELIM: begin
               w_done_nxt = 1'b1;
               w_err_nxt  = (r_crc_calc != r_crc_rx);
               w_derr_nxt = ~bus.rx_bit;
               w_ok_nxt   = (r_crc_calc == r_crc_rx) & bus.rx_bit;
            end
            default: ;
         endcase
      end
   end

   // Datapath and flag registers; busy tracks the registered state
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_crc_calc <= 15'h0;
         r_crc_rx   <= 15'h0;
         r_cnt      <= 4'd0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_ok       <= 1'b0;
         r_err      <= 1'b0;
         r_derr     <= 1'b0;
      end else begin
         r_crc_calc <= w_crc_calc_nxt;
         r_crc_rx   <= w_crc_rx_nxt;
         r_cnt      <= w_cnt_nxt;
         r_busy     <= (w_state_nxt != IDLE);
         r_done     <= w_done_nxt;
         r_ok       <= w_ok_nxt;
         r_err      <= w_err_nxt;
         r_derr     <= w_derr_nxt;
      end
   end

   assign bus.busy      = r_busy;
   assign bus.crc_calc  = r_crc_calc;
   assign bus.crc_rx    = r_crc_rx;
   assign bus.crc_done  = r_done;
   assign bus.crc_ok    = r_ok;
   assign bus.crc_err   = r_err;
   assign bus.delim_err = r_derr;

endmodule

// File: tb/tb_can_crc_check.sv
// Bench for can_crc_check: directed test-plan frames plus random frames,
// checked against a long-division CRC reference model.
module tb_can_crc_check;

   logic clk;
   logic n_rst;
   int   checks = 0;
   int   errors = 0;
   int   done_cnt = 0;

   can_crc_check_if bus ();

   can_crc_check #(.POLY(15'h4599)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Count crc_done pulses (value held over the cycle just ending)
   always @(posedge clk) if (bus.crc_done === 1'b1) done_cnt++;

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: remainder of M(x)*x^15 divided by x^15+POLY (mod-2 long division)
   function automatic logic [14:0] ref_crc(input logic [63:0] bits, input int n);
      logic [15:0] rem;
      logic        b;
      rem = 16'h0;
      for (int i = 0; i < n + 15; i++) begin
         b   = (i < n) ? bits[i] : 1'b0;
         rem = {rem[14:0], b};
         if (rem[15]) rem = rem ^ 16'hC599;
      end
      return rem[14:0];
   endfunction

   task automatic idle_inputs();
      bus.rx_valid  = 1'b0;
      bus.sof       = 1'b0;
      bus.last_data = 1'b0;
      bus.abort     = 1'b0;
   endtask

   task automatic strobe(input logic b, input logic s, input logic l, input int gap);
      @(negedge clk);
      bus.rx_valid  = 1'b1;
      bus.rx_bit    = b;
      bus.sof       = s;
      bus.last_data = l;
      repeat (gap) begin
         @(negedge clk);
         idle_inputs();
         bus.rx_bit = 1'($urandom);
      end
   endtask

   task automatic send_covered(input logic [63:0] bits, input int n, input int gap);
      for (int i = 0; i < n; i++) strobe(bits[i], i == 0, i == n - 1, gap);
   endtask

   task automatic finish_frame(input string tag, input logic [14:0] exp_calc,
                               input logic [14:0] rx_crc, input logic delim, input int gap);
      int d0;
      d0 = done_cnt;
      @(negedge clk);
      idle_inputs();
      chk({tag, " crc_calc"}, 32'(bus.crc_calc), 32'(exp_calc));
      chk({tag, " busy"}, 32'(bus.busy), 32'd1);
      for (int i = 14; i >= 0; i--) strobe(rx_crc[i], 1'b0, 1'b0, gap);
      @(negedge clk);
      idle_inputs();
      chk({tag, " crc_rx"}, 32'(bus.crc_rx), 32'(rx_crc));
      chk({tag, " no early done"}, 32'(bus.crc_done), 32'd0);
      strobe(delim, 1'b0, 1'b0, 0);
      @(negedge clk);
      idle_inputs();
      chk({tag, " crc_done"}, 32'(bus.crc_done), 32'd1);
      chk({tag, " busy low"}, 32'(bus.busy), 32'd0);
      chk({tag, " crc_ok"}, 32'(bus.crc_ok), 32'((exp_calc == rx_crc) && delim));
      chk({tag, " crc_err"}, 32'(bus.crc_err), 32'(exp_calc != rx_crc));
      chk({tag, " delim_err"}, 32'(bus.delim_err), 32'(!delim));
      @(negedge clk);
      chk({tag, " done pulse width"}, 32'(bus.crc_done), 32'd0);
      chk({tag, " done count"}, 32'(done_cnt), 32'(d0 + 1));
      chk({tag, " ok held"}, 32'(bus.crc_ok), 32'((exp_calc == rx_crc) && delim));
   endtask

   initial begin
      logic [63:0] bits;
      logic [14:0] exp_calc, rx_crc;
      logic        delim;
      int          n, gap, d0;

      n_rst = 1'b0;
      bus.rx_bit = 1'b0;
      idle_inputs();
      repeat (2) @(negedge clk);
      chk("reset busy", 32'(bus.busy), 32'd0);
      chk("reset crc_calc", 32'(bus.crc_calc), 32'd0);
      chk("reset crc_rx", 32'(bus.crc_rx), 32'd0);
      chk("reset flags", {28'd0, bus.crc_done, bus.crc_ok, bus.crc_err, bus.delim_err}, 32'd0);
      n_rst = 1'b1;
      @(negedge clk);

      // Single covered bit "1" -> 0x4599, matching CRC, recessive delimiter
      bits = 64'h1;
      chk("model 1", 32'(ref_crc(bits, 1)), 32'h4599);
      send_covered(bits, 1, 0);
      finish_frame("tp1", 15'h4599, 15'h4599, 1'b1, 0);

      // "1","0" -> 0x4EAB, received 0x4EAA -> CRC error
      bits = 64'h1;
      chk("model 10", 32'(ref_crc(bits, 2)), 32'h4EAB);
      send_covered(bits, 2, 0);
      finish_frame("tp2", 15'h4EAB, 15'h4EAA, 1'b1, 0);

      // Abort in IDLE clears flags but holds crc_calc/crc_rx
      @(negedge clk); bus.abort = 1'b1;
      @(negedge clk); idle_inputs();
      chk("abort idle err clr", 32'(bus.crc_err), 32'd0);
      chk("abort idle calc hold", 32'(bus.crc_calc), 32'h4EAB);
      chk("abort idle rx hold", 32'(bus.crc_rx), 32'h4EAA);

      // "0" -> 0x0000, CRC 0, dominant delimiter -> form error only
      bits = 64'h0;
      send_covered(bits, 1, 0);
      finish_frame("tp3", 15'h0000, 15'h0000, 1'b0, 0);

      // Abort after 7 CRC bits
      d0 = done_cnt;
      rx_crc = 15'h4599;
      strobe(1'b1, 1'b1, 1'b1, 0);
      for (int i = 14; i >= 8; i--) strobe(rx_crc[i], 1'b0, 1'b0, 0);
      @(negedge clk); idle_inputs(); bus.abort = 1'b1;
      @(negedge clk); idle_inputs();
      chk("abort busy", 32'(bus.busy), 32'd0);
      chk("abort flags", {29'd0, bus.crc_ok, bus.crc_err, bus.delim_err}, 32'd0);
      repeat (3) @(negedge clk);
      chk("abort no done", 32'(done_cnt), 32'(d0));
      bits = 64'h1;
      send_covered(bits, 1, 0);
      finish_frame("post abort", 15'h4599, 15'h4599, 1'b1, 0);

      // Abort beats a simultaneous sof strobe
      @(negedge clk);
      bus.abort = 1'b1; bus.rx_valid = 1'b1; bus.sof = 1'b1; bus.rx_bit = 1'b0;
      @(negedge clk); idle_inputs();
      chk("abort vs sof busy", 32'(bus.busy), 32'd0);
      chk("abort vs sof calc", 32'(bus.crc_calc), 32'h4599);

      // sof re-asserted mid CALC restarts the CRC
      strobe(1'b1, 1'b1, 1'b0, 0);
      strobe(1'b1, 1'b0, 1'b0, 0);
      strobe(1'b0, 1'b0, 1'b0, 0);
      bits = 64'h1;
      send_covered(bits, 2, 0);
      finish_frame("restart", 15'h4EAB, 15'h4EAB, 1'b1, 0);

      // Reset while the delimiter strobe is pending
      d0 = done_cnt;
      bits = 64'h1;
      rx_crc = 15'h4599;
      send_covered(bits, 1, 0);
      for (int i = 14; i >= 0; i--) strobe(rx_crc[i], 1'b0, 1'b0, 0);
      @(negedge clk);
      bus.rx_valid = 1'b1; bus.rx_bit = 1'b1;
      #1 n_rst = 1'b0;
      #1;
      chk("rst busy", 32'(bus.busy), 32'd0);
      chk("rst calc", 32'(bus.crc_calc), 32'd0);
      chk("rst rx", 32'(bus.crc_rx), 32'd0);
      chk("rst flags", {28'd0, bus.crc_done, bus.crc_ok, bus.crc_err, bus.delim_err}, 32'd0);
      @(negedge clk); idle_inputs(); n_rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst no done", 32'(done_cnt), 32'(d0));
      chk("rst idle", 32'(bus.busy), 32'd0);

      // Sparse strobes (every 5th cycle)
      bits = 64'h1;
      send_covered(bits, 2, 4);
      finish_frame("sparse", 15'h4EAB, 15'h4EAB, 1'b1, 4);

      // Random frames against the reference model
      for (int f = 0; f < 24; f++) begin
         n        = int'($urandom_range(1, 40));
         bits     = {$urandom, $urandom};
         gap      = int'($urandom_range(0, 2));
         exp_calc = ref_crc(bits, n);
         rx_crc   = exp_calc;
         if ($urandom_range(0, 2) == 0) rx_crc = rx_crc ^ (15'h1 << $urandom_range(0, 14));
         delim    = ($urandom_range(0, 3) != 0);
         send_covered(bits, n, gap);
         finish_frame("random", exp_calc, rx_crc, delim, gap);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/can_crc_check.md
# can_crc_check

Receive-side CRC-15 checker for the CAN controller. It consumes the destuffed bit stream from the bit-timing/destuff logic and computes the CAN CRC (polynomial 0x4599) over SOF through the last data bit. It then captures the 15 transmitted CRC bits and the CRC delimiter, and reports match, CRC error, or delimiter form error to the receive FSM. It is the receiving counterpart of the transmit CRC generator.

## Interface
Parameters:
- POLY, 15'h4599, CRC generator polynomial; x^15 term implicit.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- rx_bit  in  1  destuffed received bit (0 = dominant).
- rx_valid  in  1  single-cycle strobe; rx_bit is valid and consumed this cycle.
- sof  in  1  qualified by rx_valid; marks this bit as SOF (first CRC-covered bit).
- last_data  in  1  qualified by rx_valid; marks the last CRC-covered bit (end of data field).
- abort  in  1  synchronous abort (error frame, bus-off, arbitration lost); highest priority.
- busy  out  1  high whenever state != IDLE.
- crc_calc  out  15  running or final computed CRC.
- crc_rx  out  15  captured received CRC field, MSB first.
- crc_done  out  1  one-cycle pulse when the delimiter bit has been evaluated.
- crc_ok  out  1  sticky: CRC matched and delimiter recessive.
- crc_err  out  1  sticky: crc_calc != crc_rx.
- delim_err  out  1  sticky: CRC delimiter sampled dominant.

## Operation
- Reset values: state IDLE; crc_calc, crc_rx 0; busy, crc_done, crc_ok, crc_err, delim_err 0.
- CRC update per consumed covered bit: nxt = rx_bit ^ crc_calc[14]; crc_calc = {crc_calc[13:0],1'b0} ^ (nxt ? POLY : 0). Width is fixed at 15 bits; bit 15 is discarded.
- States:
  - IDLE: ignores rx_valid unless sof. On rx_valid&sof: crc_calc is updated from an initial value of 0 with this bit. crc_rx, crc_ok, crc_err and delim_err clear. Next state is CALC, or CRC_RX if last_data is also set.
  - CALC: each rx_valid updates crc_calc. If last_data, next state is CRC_RX and the bit counter is set to 0.
  - CRC_RX: each rx_valid shifts rx_bit into crc_rx LSB (crc_rx = {crc_rx[13:0],rx_bit}) and increments a 4-bit counter. crc_calc is frozen. After the 15th bit (counter==14 when consumed), next state is DELIM.
  - DELIM: on rx_valid, crc_done pulses. crc_err = (crc_calc != crc_rx). delim_err = ~rx_bit. crc_ok = match & rx_bit. Next state is IDLE.
- Both crc_err and delim_err may assert together.
- sof while not IDLE: restart exactly as from IDLE (re-initialise and process that bit). No crc_done is issued for the abandoned frame.
- abort: next state IDLE. No crc_done. Status flags are cleared. crc_calc and crc_rx hold their values. abort beats sof and rx_valid in the same cycle.
- sof/last_data without rx_valid: ignored. last_data outside CALC (other than with sof in IDLE): ignored.

## Timing
- All outputs are registered. crc_calc reflects a bit one cycle after its rx_valid.
- crc_done and the status flags assert in the cycle after the delimiter rx_valid. crc_done is high for exactly 1 cycle; the flags hold until the next sof or abort.
- busy rises the cycle after SOF and falls in the same cycle crc_done rises.
- rx_valid may be asserted back-to-back every cycle or sparsely; the block makes no assumption on bit spacing.
- Minimum frame: 1 covered bit + 15 CRC + 1 delimiter = 17 rx_valid strobes. Latency from delimiter strobe to crc_done is 1 cycle.

## Test plan
- Covered bits "1" (sof & last_data on the same strobe) -> crc_calc=0x4599. Then feed 0x4599 MSB first and delimiter 1 -> crc_done pulse, crc_ok=1, crc_err=0, delim_err=0.
- Covered bits "1","0" (last_data on the 2nd) -> crc_calc=0x4EAB. Then feed received CRC 0x4EAA and delimiter 1 -> crc_err=1, crc_ok=0.
- Covered bit "0" only -> crc_calc=0x0000. Then feed CRC 0x0000 and delimiter 0 -> delim_err=1, crc_err=0, crc_ok=0.
- Abort asserted mid CRC_RX (after 7 CRC bits) -> busy=0 next cycle, no crc_done, flags 0. A following frame with covered bit "1", CRC 0x4599 and delimiter 1 -> crc_ok=1.
- sof re-asserted during CALC -> crc_calc restarts from 0. Frame "1","0" then gives 0x4EAB, and exactly one crc_done is seen.
- n_rst asserted in DELIM with rx_valid pending -> all outputs 0 immediately, state IDLE, no crc_done after release. Sparse rx_valid (every 5th cycle) on frame "1","0" gives results identical to back-to-back strobes.
